// File: rtl/edge_rasterizer_if.sv
// Triangle-task and pixel-stream bundle between a slice scheduler/frame-buffer
// writer (master side) and one edge_rasterizer slice (slave side).
//   task_valid/task_ready, ax..cy, color_r/g/b, depth : triangle task handshake
//   abort                                            : drop the current task
//   pix_valid/pix_ready, pix_x/y, pix_r/g/b, pix_depth : covered-pixel stream
//   task_done                                        : one-cycle completion pulse
interface edge_rasterizer_if #(
  parameter int COORD_W = 10,
  parameter int DEPTH_W = 8,
  parameter int COLOR_W = 8
);
  logic               task_valid;
  logic               task_ready;
  logic [COORD_W-1:0] ax, ay, bx, by, cx, cy;
  logic [COLOR_W-1:0] color_r, color_g, color_b;
  logic [DEPTH_W-1:0] depth;
  logic               abort;
  logic               pix_valid;
  logic               pix_ready;
  logic [COORD_W-1:0] pix_x, pix_y;
  logic [COLOR_W-1:0] pix_r, pix_g, pix_b;
  logic [DEPTH_W-1:0] pix_depth;
  logic               task_done;

  modport master (
    output task_valid, ax, ay, bx, by, cx, cy, color_r, color_g, color_b, depth,
           abort, pix_ready,
    input  task_ready, pix_valid, pix_x, pix_y, pix_r, pix_g, pix_b, pix_depth,
           task_done
  );

  modport slave (
    input  task_valid, ax, ay, bx, by, cx, cy, color_r, color_g, color_b, depth,
           abort, pix_ready,
    output task_ready, pix_valid, pix_x, pix_y, pix_r, pix_g, pix_b, pix_depth,
           task_done
  );
endinterface

// File: rtl/edge_rasterizer.sv
// Per-slice triangle rasterizer. Walks the triangle's bounding box, clipped to
// the columns owned by this slice and to the screen height, one candidate pixel
// per cycle (y inner, x outer) using incremental edge functions, and streams
// covered pixels with the flat colour/depth of the triangle.
// Ports:
//   clock_i  : system clock
//   reset_i  : synchronous active-high reset
//   bus      : edge_rasterizer_if.slave (task handshake, abort, pixel stream,
//              task_done pulse)
module edge_rasterizer #(
  parameter int COORD_W       = 10,
  parameter int DEPTH_W       = 8,
  parameter int COLOR_W       = 8,
  parameter int X_RANGE_START = 0,
  parameter int X_RANGE_END   = 29,
  parameter int HEIGHT        = 479
) (
  input logic              clock_i,
  input logic              reset_i,
  edge_rasterizer_if.slave bus
);

  // Edge values of unsigned COORD_W coordinates fit in 2*COORD_W+3 signed bits.
  localparam int EW = 2 * COORD_W + 3;
  localparam logic [COORD_W-1:0] X_LO = COORD_W'(X_RANGE_START);
  localparam logic [COORD_W-1:0] X_HI = COORD_W'(X_RANGE_END);
  localparam logic [COORD_W-1:0] Y_HI = COORD_W'(HEIGHT);

  typedef logic [COORD_W-1:0]    coord_t;
  typedef logic signed [EW-1:0]  edge_t;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP1 = 3'd1,
    S_SETUP2 = 3'd2,
    S_SCAN   = 3'd3,
    S_DRAIN  = 3'd4
  } state_t;

  function automatic coord_t min2(input coord_t a, input coord_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic coord_t max2(input coord_t a, input coord_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic edge_t sext(input coord_t c);
    return $signed({{(EW-COORD_W){1'b0}}, c});
  endfunction

  // Edge k runs from vertex k to vertex next_vtx(k): AB, BC, CA.
  function automatic int next_vtx(input int k);
    return (k == 2) ? 0 : k + 1;
  endfunction

  state_t              state_q, state_d;
  logic                task_ready_q, task_ready_d;
  logic                task_done_q, task_done_d;
  coord_t              vx_q [3], vx_d [3];
  coord_t              vy_q [3], vy_d [3];
  logic [COLOR_W-1:0]  col_r_q, col_r_d, col_g_q, col_g_d, col_b_q, col_b_d;
  logic [DEPTH_W-1:0]  dep_q, dep_d;
  coord_t              xmin_q, xmin_d, xmax_q, xmax_d;
  coord_t              ymin_q, ymin_d, ymax_q, ymax_d;
  edge_t               dex_q [3], dex_d [3];
  edge_t               dey_q [3], dey_d [3];
  edge_t               e_q [3], e_d [3];
  edge_t               cb_q [3], cb_d [3];
  coord_t              cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic                pix_valid_q, pix_valid_d;
  coord_t              pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [COLOR_W-1:0]  pix_r_q, pix_r_d, pix_g_q, pix_g_d, pix_b_q, pix_b_d;
  logic [DEPTH_W-1:0]  pix_dep_q, pix_dep_d;

  coord_t bb_xmin_s, bb_xmax_s, bb_ymin_s, bb_ymax_s;
  logic   bb_empty_s;
  logic   covered_s;
  logic   advance_s;

  // Clipped bounding box of the latched vertices.
  always_comb begin
    bb_xmin_s  = max2(min2(min2(vx_q[0], vx_q[1]), vx_q[2]), X_LO);
    bb_xmax_s  = min2(max2(max2(vx_q[0], vx_q[1]), vx_q[2]), X_HI);
    bb_ymin_s  = min2(min2(vy_q[0], vy_q[1]), vy_q[2]);
    bb_ymax_s  = min2(max2(max2(vy_q[0], vy_q[1]), vy_q[2]), Y_HI);
    bb_empty_s = (bb_xmin_s > bb_xmax_s) || (bb_ymin_s > bb_ymax_s);
  end

  // Coverage of the cursor pixel; all-zero edges mean a zero-area triangle.
  always_comb begin
    logic all_ge, all_le, all_zero;
    all_ge    = 1'b1;
    all_le    = 1'b1;
    all_zero  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      all_ge   = all_ge & ~e_q[k][EW-1];
      all_le   = all_le & (e_q[k][EW-1] | (e_q[k] == '0));
      all_zero = all_zero & (e_q[k] == '0);
    end
    covered_s = (all_ge | all_le) & ~all_zero;
    advance_s = ~pix_valid_q | bus.pix_ready;
  end

  // Next-state and datapath for the whole rasterizer.
  always_comb begin
    state_d      = state_q;
    task_ready_d = task_ready_q;
    task_done_d  = 1'b0;
    col_r_d      = col_r_q;
    col_g_d      = col_g_q;
    col_b_d      = col_b_q;
    dep_d        = dep_q;
    xmin_d       = xmin_q;
    xmax_d       = xmax_q;
    ymin_d       = ymin_q;
    ymax_d       = ymax_q;
    cur_x_d      = cur_x_q;
    cur_y_d      = cur_y_q;
    pix_valid_d  = pix_valid_q;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    pix_r_d      = pix_r_q;
    pix_g_d      = pix_g_q;
    pix_b_d      = pix_b_q;
    pix_dep_d    = pix_dep_q;
    for (int k = 0; k < 3; k++) begin
      vx_d[k]  = vx_q[k];
      vy_d[k]  = vy_q[k];
      dex_d[k] = dex_q[k];
      dey_d[k] = dey_q[k];
      e_d[k]   = e_q[k];
      cb_d[k]  = cb_q[k];
    end

    if (bus.abort) begin
      state_d      = S_IDLE;
      task_ready_d = 1'b1;
      task_done_d  = 1'b0;
      pix_valid_d  = 1'b0;
    end else begin
      if (pix_valid_q && bus.pix_ready) begin
        pix_valid_d = 1'b0;
      end else begin
        pix_valid_d = pix_valid_q;
      end

      case (state_q)
        S_IDLE: begin
          if (task_ready_q && bus.task_valid) begin
            vx_d[0] = bus.ax;
            vy_d[0] = bus.ay;
            vx_d[1] = bus.bx;
            vy_d[1] = bus.by;
            vx_d[2] = bus.cx;
            vy_d[2] = bus.cy;
            col_r_d = bus.color_r;
            col_g_d = bus.color_g;
            col_b_d = bus.color_b;
            dep_d   = bus.depth;
            state_d = S_SETUP1;
          end else begin
            state_d = S_IDLE;
          end
        end

        S_SETUP1: begin
          xmin_d = bb_xmin_s;
          xmax_d = bb_xmax_s;
          ymin_d = bb_ymin_s;
          ymax_d = bb_ymax_s;
          for (int k = 0; k < 3; k++) begin
            dex_d[k] = sext(vy_q[k]) - sext(vy_q[next_vtx(k)]);
            dey_d[k] = sext(vx_q[next_vtx(k)]) - sext(vx_q[k]);
          end
          if (bb_empty_s) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_SETUP2;
          end
        end

        S_SETUP2: begin
          for (int k = 0; k < 3; k++) begin
            e_d[k]  = dey_q[k] * (sext(ymin_q) - sext(vy_q[k]))
                    + dex_q[k] * (sext(xmin_q) - sext(vx_q[k]));
            cb_d[k] = e_d[k];
          end
          cur_x_d = xmin_q;
          cur_y_d = ymin_q;
          state_d = S_SCAN;
        end

        S_SCAN: begin
          if (advance_s) begin
            if (covered_s) begin
              pix_valid_d = 1'b1;
              pix_x_d     = cur_x_q;
              pix_y_d     = cur_y_q;
              pix_r_d     = col_r_q;
              pix_g_d     = col_g_q;
              pix_b_d     = col_b_q;
              pix_dep_d   = dep_q;
            end else begin
              pix_x_d = pix_x_q;
            end
            if (cur_y_q == ymax_q) begin
              if (cur_x_q == xmax_q) begin
                state_d = S_DRAIN;
              end else begin
                // Column wrap: restart from the column base, one step in x.
                cur_x_d = cur_x_q + COORD_W'(1);
                cur_y_d = ymin_q;
                for (int k = 0; k < 3; k++) begin
                  cb_d[k] = cb_q[k] + dex_q[k];
                  e_d[k]  = cb_q[k] + dex_q[k];
                end
              end
            end else begin
              cur_y_d = cur_y_q + COORD_W'(1);
              for (int k = 0; k < 3; k++) begin
                e_d[k] = e_q[k] + dey_q[k];
              end
            end
          end else begin
            state_d = S_SCAN;
          end
        end

        S_DRAIN: begin
          if (!pix_valid_q || bus.pix_ready) begin
            task_done_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            state_d = S_DRAIN;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase

      // Ready is withheld for the IDLE cycle that carries task_done.
      task_ready_d = (state_q == S_IDLE) && (state_d == S_IDLE);
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      task_ready_q <= 1'b1;
      task_done_q  <= 1'b0;
      col_r_q      <= '0;
      col_g_q      <= '0;
      col_b_q      <= '0;
      dep_q        <= '0;
      xmin_q       <= '0;
      xmax_q       <= '0;
      ymin_q       <= '0;
      ymax_q       <= '0;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      pix_valid_q  <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_r_q      <= '0;
      pix_g_q      <= '0;
      pix_b_q      <= '0;
      pix_dep_q    <= '0;
      for (int k = 0; k < 3; k++) begin
        vx_q[k]  <= '0;
        vy_q[k]  <= '0;
        dex_q[k] <= '0;
        dey_q[k] <= '0;
        e_q[k]   <= '0;
        cb_q[k]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      task_ready_q <= task_ready_d;
      task_done_q  <= task_done_d;
      col_r_q      <= col_r_d;
      col_g_q      <= col_g_d;
      col_b_q      <= col_b_d;
      dep_q        <= dep_d;
      xmin_q       <= xmin_d;
      xmax_q       <= xmax_d;
      ymin_q       <= ymin_d;
      ymax_q       <= ymax_d;
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
      pix_valid_q  <= pix_valid_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      pix_r_q      <= pix_r_d;
      pix_g_q      <= pix_g_d;
      pix_b_q      <= pix_b_d;
      pix_dep_q    <= pix_dep_d;
      for (int k = 0; k < 3; k++) begin
        vx_q[k]  <= vx_d[k];
        vy_q[k]  <= vy_d[k];
        dex_q[k] <= dex_d[k];
        dey_q[k] <= dey_d[k];
        e_q[k]   <= e_d[k];
        cb_q[k]  <= cb_d[k];
      end
    end
  end

  assign bus.task_ready = task_ready_q;
  assign bus.task_done  = task_done_q;
  assign bus.pix_valid  = pix_valid_q;
  assign bus.pix_x      = pix_x_q;
  assign bus.pix_y      = pix_y_q;
  assign bus.pix_r      = pix_r_q;
  assign bus.pix_g      = pix_g_q;
  assign bus.pix_b      = pix_b_q;
  assign bus.pix_depth  = pix_dep_q;

endmodule

// File: tb/tb_edge_rasterizer.sv
module tb_edge_rasterizer;
  localparam int CW = 10;
  localparam int DW = 8;
  localparam int LW = 8;
  localparam int XS = 0;
  localparam int XE = 29;
  localparam int H  = 479;

  typedef logic [51:0] pix_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  edge_rasterizer_if #(.COORD_W(CW), .DEPTH_W(DW), .COLOR_W(LW)) bus ();

  edge_rasterizer #(
    .COORD_W(CW), .DEPTH_W(DW), .COLOR_W(LW),
    .X_RANGE_START(XS), .X_RANGE_END(XE), .HEIGHT(H)
  ) dut (
    .clock_i(clk),
    .reset_i(rst),
    .bus    (bus)
  );

  pix_t got_q[$];
  pix_t exp_q[$];
  pix_t ref1_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_k, first_k, stall_viol, overlap_viol;
  bit   timed_out;
  logic [7:0] t_r, t_g, t_b, t_d;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Reference: every pixel in the clipped box whose edge values all share the
  // sign of the triangle's signed area, listed column by column.
  function automatic int build_exp(input int ax, ay, bx, by, cx, cy);
    int area, xlo, xhi, ylo, yhi, s, e0, e1, e2;
    exp_q.delete();
    xlo = imax(imin(imin(ax, bx), cx), XS);
    xhi = imin(imax(imax(ax, bx), cx), XE);
    ylo = imin(imin(ay, by), cy);
    yhi = imin(imax(imax(ay, by), cy), H);
    if (xlo > xhi || ylo > yhi) return 0;
    area = (bx - ax) * (cy - ay) - (by - ay) * (cx - ax);
    s = (area > 0) ? 1 : -1;
    if (area != 0) begin
      for (int x = xlo; x <= xhi; x++) begin
        for (int y = ylo; y <= yhi; y++) begin
          e0 = (bx - ax) * (y - ay) - (by - ay) * (x - ax);
          e1 = (cx - bx) * (y - by) - (cy - by) * (x - bx);
          e2 = (ax - cx) * (y - cy) - (ay - cy) * (x - cx);
          if (e0 * s >= 0 && e1 * s >= 0 && e2 * s >= 0)
            exp_q.push_back({CW'(x), CW'(y), t_r, t_g, t_b, t_d});
        end
      end
    end
    return (xhi - xlo + 1) * (yhi - ylo + 1);
  endfunction

  function automatic int count_diff(input pix_t a[$], input pix_t b[$]);
    int d;
    d = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
    for (int i = 0; i < imin(a.size(), b.size()); i++)
      if (a[i] !== b[i]) d++;
    return d;
  endfunction

  // Offers one triangle and plays the pixel writer until task_done, an abort
  // point (abort_after accepted pixels, -1 = never) or the cycle budget.
  task automatic run_tri(input int ax, ay, bx, by, cx, cy,
                         input int ready_pct, input int abort_after,
                         input int budget);
    int   k;
    bit   fin, hold, rdy;
    pix_t held, cur;
    got_q.delete();
    done_k = -1; first_k = -1; stall_viol = 0; overlap_viol = 0;
    timed_out = 1'b0;
    t_r = 8'($urandom); t_g = 8'($urandom); t_b = 8'($urandom); t_d = 8'($urandom);
    k = 0;
    @(negedge clk);
    while (bus.task_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (bus.task_ready !== 1'b1) begin
      timed_out = 1'b1;
      return;
    end
    bus.ax = CW'(ax); bus.ay = CW'(ay); bus.bx = CW'(bx);
    bus.by = CW'(by); bus.cx = CW'(cx); bus.cy = CW'(cy);
    bus.color_r = t_r; bus.color_g = t_g; bus.color_b = t_b; bus.depth = t_d;
    bus.task_valid = 1'b1;
    @(negedge clk);
    bus.task_valid = 1'b0;
    k = 1; fin = 1'b0; hold = 1'b0; held = '0;
    while (!fin && k <= budget) begin
      cur = {bus.pix_x, bus.pix_y, bus.pix_r, bus.pix_g, bus.pix_b, bus.pix_depth};
      if (bus.task_done === 1'b1 && bus.task_ready === 1'b1) overlap_viol++;
      if (hold && (bus.pix_valid !== 1'b1 || cur !== held)) stall_viol++;
      if (bus.task_done === 1'b1) begin
        done_k = k;
        fin = 1'b1;
      end else if (abort_after >= 0 && got_q.size() == abort_after) begin
        bus.pix_ready = 1'b0;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        return;
      end else begin
        rdy = ($urandom_range(99) < ready_pct);
        bus.pix_ready = rdy;
        if (bus.pix_valid === 1'b1) begin
          if (first_k < 0) first_k = k;
          if (rdy) got_q.push_back(cur);
          hold = !rdy;
          held = cur;
        end else begin
          hold = 1'b0;
        end
        @(negedge clk);
        k++;
      end
    end
    if (!fin) timed_out = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.task_valid = 1'b0; bus.abort = 1'b0; bus.pix_ready = 1'b0;
    bus.ax = '0; bus.ay = '0; bus.bx = '0; bus.by = '0; bus.cx = '0; bus.cy = '0;
    bus.color_r = '0; bus.color_g = '0; bus.color_b = '0; bus.depth = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.task_ready !== 1'b1 || bus.pix_valid !== 1'b0 || bus.task_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: ready=%b valid=%b done=%b, expected 1 0 0",
               bus.task_ready, bus.pix_valid, bus.task_done);
    end
    n_checks++;
    if ({bus.pix_x, bus.pix_y, bus.pix_r, bus.pix_g, bus.pix_b, bus.pix_depth} !== 52'd0) begin
      n_fail++;
      $display("FAIL reset_pix: pixel regs=%h, expected 0",
               {bus.pix_x, bus.pix_y, bus.pix_r, bus.pix_g, bus.pix_b, bus.pix_depth});
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.task_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_after: task_ready=%b, expected 1", bus.task_ready);
    end
  endtask

  task automatic test_tri1();
    int nc, d;
    run_tri(0, 0, 29, 0, 0, 29, 100, -1, 3000);
    nc = build_exp(0, 0, 29, 0, 0, 29);
    ref1_q = exp_q;
    d = count_diff(got_q, exp_q);
    n_checks++;
    if (got_q.size() != 465 || d != 0) begin
      n_fail++;
      $display("FAIL tri1_pixels: got %0d pixels (%0d differ), expected 465", got_q.size(), d);
    end
    n_checks++;
    if (first_k != 4) begin
      n_fail++;
      $display("FAIL tri1_first_latency: first pixel at cycle %0d, expected 4", first_k);
    end
    n_checks++;
    if (timed_out || done_k != 4 + nc) begin
      n_fail++;
      $display("FAIL tri1_done: task_done at cycle %0d (timeout=%0d), expected %0d",
               done_k, timed_out, 4 + nc);
    end
    n_checks++;
    if (overlap_viol != 0) begin
      n_fail++;
      $display("FAIL tri1_done_ready_overlap: %0d cycles, expected 0", overlap_viol);
    end
  endtask

  task automatic test_winding();
    int d;
    run_tri(0, 0, 0, 29, 29, 0, 100, -1, 3000);
    t_r = got_q.size() > 0 ? got_q[0][31:24] : t_r;
    d = count_diff(got_q, ref1_q);
    // Colour differs from the first run, so compare coordinates only.
    d = 0;
    for (int i = 0; i < imin(got_q.size(), ref1_q.size()); i++)
      if (got_q[i][51:32] !== ref1_q[i][51:32]) d++;
    n_checks++;
    if (got_q.size() != ref1_q.size() || d != 0 || timed_out) begin
      n_fail++;
      $display("FAIL winding_pixels: got %0d pixels (%0d differ, timeout=%0d), expected %0d",
               got_q.size(), d, timed_out, ref1_q.size());
    end
  endtask

  task automatic test_offslice();
    run_tri(100, 10, 120, 10, 110, 30, 100, -1, 200);
    n_checks++;
    if (got_q.size() != 0) begin
      n_fail++;
      $display("FAIL offslice_pixels: got %0d pixels, expected 0", got_q.size());
    end
    n_checks++;
    if (done_k != 3) begin
      n_fail++;
      $display("FAIL offslice_done: task_done at cycle %0d, expected 3", done_k);
    end
  endtask

  task automatic test_stall();
    int d;
    run_tri(0, 0, 29, 0, 0, 29, 30, -1, 8000);
    void'(build_exp(0, 0, 29, 0, 0, 29));
    d = count_diff(got_q, exp_q);
    n_checks++;
    if (got_q.size() != 465 || d != 0 || timed_out) begin
      n_fail++;
      $display("FAIL stall_pixels: got %0d pixels (%0d differ, timeout=%0d), expected 465",
               got_q.size(), d, timed_out);
    end
    n_checks++;
    if (stall_viol != 0) begin
      n_fail++;
      $display("FAIL stall_stability: %0d unstable stall cycles, expected 0", stall_viol);
    end
    n_checks++;
    if (overlap_viol != 0) begin
      n_fail++;
      $display("FAIL stall_done_ready_overlap: %0d cycles, expected 0", overlap_viol);
    end
  endtask

  task automatic test_degenerate();
    int nc;
    run_tri(5, 5, 10, 10, 15, 15, 100, -1, 500);
    nc = build_exp(5, 5, 10, 10, 15, 15);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL degenerate_pixels: got %0d pixels, expected %0d", got_q.size(), exp_q.size());
    end
    n_checks++;
    if (done_k != 4 + nc) begin
      n_fail++;
      $display("FAIL degenerate_done: task_done at cycle %0d, expected %0d", done_k, 4 + nc);
    end
  endtask

  task automatic test_abort();
    int d, bad;
    pix_t first100[$];
    run_tri(0, 0, 29, 0, 0, 29, 100, 100, 3000);
    void'(build_exp(0, 0, 29, 0, 0, 29));
    n_checks++;
    if (bus.pix_valid !== 1'b0 || bus.task_ready !== 1'b1 || bus.task_done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_next_cycle: valid=%b ready=%b done=%b, expected 0 1 0",
               bus.pix_valid, bus.task_ready, bus.task_done);
    end
    for (int i = 0; i < 100; i++) first100.push_back(exp_q[i]);
    d = count_diff(got_q, first100);
    n_checks++;
    if (d != 0) begin
      n_fail++;
      $display("FAIL abort_prefix: got %0d pixels (%0d differ), expected first 100", got_q.size(), d);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.task_done !== 1'b0 || bus.pix_valid !== 1'b0) bad++;
      @(negedge clk);
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL abort_quiet: %0d cycles with done/valid after abort, expected 0", bad);
    end
    run_tri(0, 0, 29, 0, 0, 29, 100, -1, 3000);
    void'(build_exp(0, 0, 29, 0, 0, 29));
    d = count_diff(got_q, exp_q);
    n_checks++;
    if (d != 0 || timed_out) begin
      n_fail++;
      $display("FAIL abort_recovery: got %0d pixels (%0d differ, timeout=%0d), expected %0d",
               got_q.size(), d, timed_out, exp_q.size());
    end
  endtask

  task automatic test_abort_accept();
    int bad;
    @(negedge clk);
    bus.ax = CW'(0); bus.ay = CW'(0); bus.bx = CW'(29);
    bus.by = CW'(0); bus.cx = CW'(0); bus.cy = CW'(29);
    bus.task_valid = 1'b1;
    bus.abort = 1'b1;
    bus.pix_ready = 1'b1;
    @(negedge clk);
    bus.task_valid = 1'b0;
    bus.abort = 1'b0;
    n_checks++;
    if (bus.task_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_blocks_accept: task_ready=%b, expected 1", bus.task_ready);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.pix_valid !== 1'b0 || bus.task_done !== 1'b0) bad++;
      @(negedge clk);
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL abort_blocks_activity: %0d active cycles, expected 0", bad);
    end
  endtask

  task automatic test_random();
    int v[6], pct, d, ybase;
    for (int t = 0; t < 8; t++) begin
      ybase = (t % 2 == 1) ? 440 : 0;
      for (int i = 0; i < 3; i++) begin
        v[2*i]   = $urandom_range(45);
        v[2*i+1] = ybase + $urandom_range(60);
      end
      pct = $urandom_range(100, 40);
      run_tri(v[0], v[1], v[2], v[3], v[4], v[5], pct, -1, 8000);
      void'(build_exp(v[0], v[1], v[2], v[3], v[4], v[5]));
      d = count_diff(got_q, exp_q);
      n_checks++;
      if (d != 0 || timed_out || stall_viol != 0 || overlap_viol != 0) begin
        n_fail++;
        $display("FAIL random_tri%0d (%0d,%0d)(%0d,%0d)(%0d,%0d): got %0d px, %0d differ, timeout=%0d stall=%0d overlap=%0d; expected %0d px",
                 t, v[0], v[1], v[2], v[3], v[4], v[5], got_q.size(), d, timed_out,
                 stall_viol, overlap_viol, exp_q.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_tri1();
    test_winding();
    test_offslice();
    test_stall();
    test_degenerate();
    test_abort();
    test_abort_accept();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
